// File: rtl/gpu_feeder_pkg.sv
// Shared types and constants for the CPU->VRAM pixel feeder.
// Holds the feeder FSM state enum and the counter/size limits.
package gpu_feeder_pkg;

   localparam int PIX_CNT_W  = 20;
   localparam int WORD_CNT_W = 19;
   localparam int MAX_W      = 1024;
   localparam int MAX_H      = 512;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN
   } feeder_state_t;

endpackage

// File: rtl/gpu_pix_lane_fifo.sv
// 16-bit show-ahead synchronous FIFO used for one pixel lane.
// Ports: i_clk, i_rst (sync, active-high), i_flush, i_push/i_data,
//        i_pop, o_data (head, 0 when empty), o_full, o_empty.
module gpu_pix_lane_fifo
   import gpu_feeder_pkg::*;
#(
   parameter int LANE_DEPTH = 4,
   parameter int LANE_AW    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic        i_push,
   input  logic [15:0] i_data,
   input  logic        i_pop,
   output logic [15:0] o_data,
   output logic        o_full,
   output logic        o_empty
);

   logic [15:0]      r_mem [LANE_DEPTH];
   logic [LANE_AW:0] r_wp;
   logic [LANE_AW:0] r_rp;
   logic             w_pop;
   logic             w_push;

   localparam logic [LANE_AW:0] PTR_ONE = {{LANE_AW{1'b0}}, 1'b1};

   assign o_empty = (r_wp == r_rp);
   // Extra pointer bit tells full from empty when the indices match.
   assign o_full  = (r_wp[LANE_AW] != r_rp[LANE_AW]) &&
                    (r_wp[LANE_AW-1:0] == r_rp[LANE_AW-1:0]);

   // Pops on empty are dropped; a same-cycle pop frees room on full.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + PTR_ONE;
         if (w_pop)  r_rp <= r_rp + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) r_mem[r_wp[LANE_AW-1:0]] <= i_data;
   end

   assign o_data = o_empty ? 16'h0000 : r_mem[r_rp[LANE_AW-1:0]];

endmodule

// File: rtl/gpu_cpuvram_pixel_feeder.sv
// Splits 32-bit GP0 words into Left/Middle 16-bit pixel lanes for the
// CPU->VRAM copy engine, counting W*H pixels and dropping odd padding.
// Ports: i_clk, i_rst (sync, active-high), i_start, i_sizeW, i_sizeH,
//        i_wordValid/i_word/o_wordRead (command FIFO side),
//        o_canReadL/M, i_readL/M, o_dataL/M (lane side), o_busy, o_done.
// Optional: define GPU_FEEDER_ABORT_EN to add the i_abort input.
module gpu_cpuvram_pixel_feeder
   import gpu_feeder_pkg::*;
#(
   parameter int LANE_DEPTH = 4,
   parameter int LANE_AW    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [10:0] i_sizeW,
   input  logic [9:0]  i_sizeH,
   input  logic        i_wordValid,
   input  logic [31:0] i_word,
   output logic        o_wordRead,
   output logic        o_canReadL,
   output logic        o_canReadM,
   input  logic        i_readL,
   input  logic        i_readM,
   output logic [15:0] o_dataL,
   output logic [15:0] o_dataM,
`ifdef GPU_FEEDER_ABORT_EN
   input  logic        i_abort,
`endif
   output logic        o_busy,
   output logic        o_done
);

   feeder_state_t         r_state;
   feeder_state_t         w_next;
   logic [10:0]           r_w;
   logic [9:0]            r_h;
   logic [WORD_CNT_W-1:0] r_wordsLeft;
   logic                  r_oddTail;
   logic                  r_done;
   logic                  w_setDone;
   logic [PIX_CNT_W-1:0]  w_pix;
   logic [WORD_CNT_W-1:0] w_wordsInit;
   logic                  w_lastWord;
   logic                  w_needM;
   logic                  w_abort;
   logic                  w_fullL;
   logic                  w_fullM;
   logic                  w_emptyL;
   logic                  w_emptyM;

`ifdef GPU_FEEDER_ABORT_EN
   assign w_abort = i_abort & (r_state != ST_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   assign w_pix = PIX_CNT_W'(r_w) * PIX_CNT_W'(r_h);
   // Round up to whole words: an odd count leaves a padding half-word.
   assign w_wordsInit = w_pix[PIX_CNT_W-1:1] +
                        {{(WORD_CNT_W-1){1'b0}}, w_pix[0]};

   assign w_lastWord = (r_wordsLeft == WORD_CNT_W'(1));
   assign w_needM    = ~(w_lastWord & r_oddTail);

   always_comb begin
      w_next     = r_state;
      o_wordRead = 1'b0;
      w_setDone  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_start) w_next = ST_LOAD;
         end
         ST_LOAD: begin
            w_next = ST_STREAM;
         end
         ST_STREAM: begin
            o_wordRead = i_wordValid & ~w_fullL &
                         (~w_fullM | ~w_needM) & ~w_abort;
            if (o_wordRead && w_lastWord) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_emptyL && w_emptyM) begin
               w_next    = ST_IDLE;
               w_setDone = 1'b1;
            end
         end
      endcase
      if (w_abort) begin
         w_next    = ST_IDLE;
         w_setDone = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_w         <= '0;
         r_h         <= '0;
         r_wordsLeft <= '0;
         r_oddTail   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_setDone;
         if (r_state == ST_IDLE && i_start) begin
            r_w <= i_sizeW;
            r_h <= i_sizeH;
         end
         if (r_state == ST_LOAD) begin
            r_wordsLeft <= w_wordsInit;
            r_oddTail   <= w_pix[0];
         end
         if (o_wordRead) r_wordsLeft <= r_wordsLeft - WORD_CNT_W'(1);
         if (w_abort) begin
            r_wordsLeft <= '0;
            r_oddTail   <= 1'b0;
         end
      end
   end

   // Done is registered, so it lands in the first IDLE cycle.
   assign o_done     = r_done;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_canReadL = ~w_emptyL;
   assign o_canReadM = ~w_emptyM;

   gpu_pix_lane_fifo #(
      .LANE_DEPTH (LANE_DEPTH),
      .LANE_AW    (LANE_AW)
   ) u_lane_l (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (w_abort),
      .i_push  (o_wordRead),
      .i_data  (i_word[15:0]),
      .i_pop   (i_readL),
      .o_data  (o_dataL),
      .o_full  (w_fullL),
      .o_empty (w_emptyL)
   );

   gpu_pix_lane_fifo #(
      .LANE_DEPTH (LANE_DEPTH),
      .LANE_AW    (LANE_AW)
   ) u_lane_m (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (w_abort),
      .i_push  (o_wordRead & w_needM),
      .i_data  (i_word[31:16]),
      .i_pop   (i_readM),
      .o_data  (o_dataM),
      .o_full  (w_fullM),
      .o_empty (w_emptyM)
   );

endmodule

// File: tb/tb_gpu_cpuvram_pixel_feeder.sv
// Self-checking bench for gpu_cpuvram_pixel_feeder: table of transfers
// plus hand-written odd-tail and mid-transfer reset sequences.
module tb_gpu_cpuvram_pixel_feeder;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [10:0] i_sizeW;
   logic [9:0]  i_sizeH;
   logic        i_wordValid;
   logic [31:0] i_word;
   logic        o_wordRead;
   logic        o_canReadL;
   logic        o_canReadM;
   logic        i_readL;
   logic        i_readM;
   logic [15:0] o_dataL;
   logic [15:0] o_dataM;
   logic        o_busy;
   logic        o_done;
`ifdef GPU_FEEDER_ABORT_EN
   logic        i_abort = 1'b0;
`endif

   always #5 clk = ~clk;

   gpu_cpuvram_pixel_feeder #(
      .LANE_DEPTH (4),
      .LANE_AW    (2)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_sizeW     (i_sizeW),
      .i_sizeH     (i_sizeH),
      .i_wordValid (i_wordValid),
      .i_word      (i_word),
      .o_wordRead  (o_wordRead),
      .o_canReadL  (o_canReadL),
      .o_canReadM  (o_canReadM),
      .i_readL     (i_readL),
      .i_readM     (i_readM),
      .o_dataL     (o_dataL),
      .o_dataM     (o_dataM),
`ifdef GPU_FEEDER_ABORT_EN
      .i_abort     (i_abort),
`endif
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   typedef struct {
      int w; int h; int perM; int idle; int mid; int base;
      int expPops; int expNL; int expNM; int expIdle; int expSpan;
   } vec_t;

   vec_t        tbl [6];
   logic [31:0] src [$];
   logic [15:0] gotL [$];
   logic [15:0] gotM [$];
   int n_chk = 0;
   int n_fail = 0;
   int idx, pops, dones, cyc, rdM_per;
   int firstPop, lastPop, lastData, doneCyc, busyAtDone, badPop;
   bit rd_en;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, then record the handshakes
   // that the coming rising edge will commit.
   task automatic cycle(input bit st, input int w, input int h);
      @(negedge clk);
      i_start     = st;
      i_sizeW     = 11'(w);
      i_sizeH     = 10'(h);
      i_wordValid = (idx < src.size());
      i_word      = i_wordValid ? src[idx] : 32'h0;
      i_readL     = rd_en;
      i_readM     = rd_en && (cyc % rdM_per == 0);
      #1;
      if (o_wordRead) begin
         if (!i_wordValid) badPop++;
         if (pops == 0) firstPop = cyc;
         lastPop = cyc;
         idx++;
         pops++;
      end
      if (i_readL && o_canReadL) gotL.push_back(o_dataL);
      if (i_readM && o_canReadM) gotM.push_back(o_dataM);
      if (o_canReadL || o_canReadM) lastData = cyc;
      if (o_done) begin
         dones++;
         doneCyc = cyc;
         if (o_busy) busyAtDone++;
      end
      cyc++;
   endtask

   task automatic run_xfer(input vec_t v, input string nm);
      int t;
      int words;
      int errs;
      idx = 0; pops = 0; dones = 0; cyc = 0; badPop = 0;
      firstPop = 0; lastPop = 0; lastData = 0; doneCyc = 0;
      busyAtDone = 0;
      gotL.delete(); gotM.delete();
      rdM_per = v.perM;
      rd_en = (v.idle == 0);
      cycle(1'b1, v.w, v.h);
      if (v.idle > 0) begin
         repeat (v.idle) cycle(1'b0, 0, 0);
         chk({nm, " idle pops"}, pops, v.expIdle);
         chk({nm, " stall rd"}, {31'd0, o_wordRead}, 0);
         chk({nm, " stall vld"}, {31'd0, i_wordValid}, 1);
         rd_en = 1'b1;
      end
      t = 0;
      while (dones == 0 && t < 4 * v.expPops + 60) begin
         if (v.mid != 0 && t == 20) cycle(1'b1, 2, 1);
         else cycle(1'b0, 0, 0);
         t++;
      end
      chk({nm, " done seen"}, dones, 1);
      repeat (4) cycle(1'b0, 0, 0);
      chk({nm, " pops"}, pops, v.expPops);
      chk({nm, " bad pops"}, badPop, 0);
      chk({nm, " L count"}, gotL.size(), v.expNL);
      chk({nm, " M count"}, gotM.size(), v.expNM);
      errs = 0;
      words = (src.size() < gotL.size()) ? src.size() : gotL.size();
      for (int i = 0; i < words; i++)
         if (gotL[i] != src[i][15:0]) errs++;
      chk({nm, " L data"}, errs, 0);
      errs = 0;
      words = (src.size() < gotM.size()) ? src.size() : gotM.size();
      for (int i = 0; i < words; i++)
         if (gotM[i] != src[i][31:16]) errs++;
      chk({nm, " M data"}, errs, 0);
      chk({nm, " single done"}, dones, 1);
      chk({nm, " busy at done"}, busyAtDone, 0);
      chk({nm, " done delay"}, doneCyc - lastData, 2);
      if (v.expSpan >= 0)
         chk({nm, " pop span"}, lastPop - firstPop, v.expSpan);
   endtask

   task automatic fill(input int n, input int base);
      src.delete();
      for (int k = 0; k < n; k++)
         src.push_back({16'(base + 2 * k + 1), 16'(base + 2 * k)});
   endtask

   initial begin
      vec_t v;
      //            w    h  pM idl mid base      pops NL  NM  idle span
      tbl[0] = '{   4,   2, 1,  0, 0, 1,           4,  4,  4, -1,   3};
      tbl[1] = '{  16,   1, 1, 10, 0, 32'h1000,    8,  8,  8,  4,  -1};
      tbl[2] = '{   8,   1, 3,  0, 0, 32'h2000,    4,  4,  4, -1,  -1};
      tbl[3] = '{1024,   1, 1,  0, 1, 32'h3000,  512,512,512, -1, 511};
      tbl[4] = '{   1,   1, 1,  0, 0, 32'h4000,    1,  1,  0, -1,   0};
      tbl[5] = '{   5,   3, 2,  0, 0, 32'h5000,    8,  8,  7, -1,  -1};

      i_rst = 1'b1; i_start = 1'b0; i_sizeW = '0; i_sizeH = '0;
      i_wordValid = 1'b1; i_word = 32'hFFFF_FFFF;
      i_readL = 1'b0; i_readM = 1'b0;
      rd_en = 1'b0; rdM_per = 1;
      repeat (3) @(negedge clk);
      i_rst = 1'b0;
      #1;
      chk("rst busy", {31'd0, o_busy}, 0);
      chk("rst done", {31'd0, o_done}, 0);
      chk("rst wordRead", {31'd0, o_wordRead}, 0);
      chk("rst canReadL", {31'd0, o_canReadL}, 0);
      chk("rst canReadM", {31'd0, o_canReadM}, 0);
      chk("rst dataL", o_dataL, 0);
      chk("rst dataM", o_dataM, 0);

      for (int r = 0; r < 6; r++) begin
         fill(tbl[r].expPops + 2, tbl[r].base);
         run_xfer(tbl[r], $sformatf("vec%0d", r));
      end
      chk("vec0 L first", gotL.size() > 0 ? 1 : 0, 1);

      // Odd tail: the upper half of the last word must be dropped.
      src.delete();
      src.push_back(32'hBBBB_AAAA);
      src.push_back(32'hDEAD_CCCC);
      src.push_back(32'h1234_5678);
      v = '{3, 1, 1, 0, 0, 0, 2, 2, 1, -1, 1};
      run_xfer(v, "odd3x1");
      chk("odd L0", gotL.size() > 0 ? gotL[0] : 0, 16'hAAAA);
      chk("odd L1", gotL.size() > 1 ? gotL[1] : 0, 16'hCCCC);
      chk("odd M0", gotM.size() > 0 ? gotM[0] : 0, 16'hBBBB);

      // Reset landing on the third pop of a long transfer.
      fill(130, 32'h6000);
      idx = 0; pops = 0; dones = 0; cyc = 0; rdM_per = 1;
      rd_en = 1'b1;
      cycle(1'b1, 64, 4);
      for (int t = 0; t < 20 && pops < 3; t++) cycle(1'b0, 0, 0);
      chk("rst3 reached", pops, 3);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      rd_en = 1'b0;
      #1;
      chk("rst3 busy", {31'd0, o_busy}, 0);
      chk("rst3 canL", {31'd0, o_canReadL}, 0);
      chk("rst3 canM", {31'd0, o_canReadM}, 0);
      chk("rst3 done", {31'd0, o_done}, 0);
      dones = 0;
      repeat (5) cycle(1'b0, 0, 0);
      chk("rst3 no done", dones, 0);
      fill(3, 32'h7000);
      v = '{2, 1, 1, 0, 0, 32'h7000, 1, 1, 1, -1, 0};
      run_xfer(v, "post rst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
